memory_access: RTL and testbench

- Memory stage of the five-stage RV64 pipeline, directly downstream of execute.
- Registers the execute_data_t bundle and issues loads/stores on the data bus (dbus) through a valid/addr_ok/data_ok handshake.
- Aligns store data and generates byte strobes; shifts and sign- or zero-extends load data.
- Stalls upstream stages while a bus transaction is in flight, then emits a registered memory_data_t to writeback.

---
 rtl/memory_access_pkg.sv | 53 +++++
 rtl/memory_access_format.sv | 26 ++
 rtl/memory_access.sv | 71 +++++++
 tb/tb_memory_access.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types for the memory stage, the execute/writeback bundles and the data bus
package memory_access_pkg;
  localparam int AXI_WORD_BYTES = 8;
  typedef logic [63:0] word_t;
  typedef logic [AXI_WORD_BYTES-1:0] strobe_t;
  typedef logic [4:0] op_t;
  typedef logic [4:0] creg_addr_t;
  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
  typedef enum logic [1:0] {IDLE, ADDR_WAIT, DATA_WAIT} mem_state_t;
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic mem_unsigned;
    msize_t msize;
    op_t op;
  } control_t;
  typedef struct packed {
    word_t pc;
    logic [31:0] instruction;
    word_t result;
    word_t memdata;
    creg_addr_t dst;
    control_t ctl;
  } execute_data_t;
  typedef struct packed {
    word_t pc;
    logic [31:0] instruction;
    word_t result;
    creg_addr_t dst;
    logic regwrite;
    op_t op;
    logic misalign;
  } memory_data_t;
  typedef struct packed {
    logic valid;
    word_t addr;
    logic [2:0] size;
    strobe_t strobe;
    word_t data;
  } dbus_req_t;
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    word_t data;
  } dbus_resp_t;
  function automatic logic [2:0] align_mask(msize_t m);
    return 3'((4'd1 << m) - 4'd1);
  endfunction
  function automatic strobe_t byte_mask(msize_t m);
    return strobe_t'((9'd1 << (4'd1 << m)) - 9'd1);
  endfunction
endpackage

// File: rtl/memory_access_format.sv
// mem_format: store data shift/strobe generation and load extract/extend
// ports: off (byte offset), msize, mem_unsigned, memdata (store value), rdata (bus beat) -> wdata, strobe, ldata
module mem_format
  import memory_access_pkg::*;
(
  input  logic [2:0] off,
  input  msize_t     msize,
  input  logic       mem_unsigned,
  input  word_t      memdata,
  input  word_t      rdata,
  output word_t      wdata,
  output strobe_t    strobe,
  output word_t      ldata
);
  word_t raw;
  logic s1, s2, s4;
  assign wdata  = memdata << {off, 3'b000};
  assign strobe = byte_mask(msize) << off;
  assign raw    = rdata >> {off, 3'b000};
  assign s1     = !mem_unsigned & raw[7];
  assign s2     = !mem_unsigned & raw[15];
  assign s4     = !mem_unsigned & raw[31];
  assign ldata  = msize == MSIZE1 ? {{56{s1}}, raw[7:0]}  :
                  msize == MSIZE2 ? {{48{s2}}, raw[15:0]} :
                  msize == MSIZE4 ? {{32{s4}}, raw[31:0]} : raw;
endmodule

// File: rtl/memory_access.sv
// memory_access: RV64 memory stage; issues dbus loads/stores, stalls upstream while busy, registers dataM
// ports: clk, reset, dataE_valid/dataE (from execute), dreq/dresp (data bus), stall_m, dataM_valid/dataM (to writeback)
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          dataE_valid,
  input  execute_data_t dataE,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          stall_m,
  output logic          dataM_valid,
  output memory_data_t  dataM
);
  logic v, mem, misalign, go, req, done;
  execute_data_t e;
  mem_state_t state, state_n;
  word_t wdata, ldata;
  strobe_t strobe;
  mem_format u_fmt (
    .off(e.result[2:0]),
    .msize(e.ctl.msize),
    .mem_unsigned(e.ctl.mem_unsigned),
    .memdata(e.memdata),
    .rdata(dresp.data),
    .wdata(wdata),
    .strobe(strobe),
    .ldata(ldata)
  );
  assign mem      = v & (e.ctl.memread | e.ctl.memwrite);
  assign misalign = mem & |(e.result[2:0] & align_mask(e.ctl.msize));
  assign go       = mem & !misalign;
  assign req      = go & (state != DATA_WAIT);
  // a data_ok only completes the access once the request is actually out
  assign done     = dresp.data_ok & (req | state == DATA_WAIT);
  assign stall_m  = go & !done;
  assign state_n  = done ? IDLE : req ? (dresp.addr_ok ? DATA_WAIT : ADDR_WAIT) : state;
  assign dreq = '{
    valid:  req,
    addr:   e.result,
    size:   {1'b0, e.ctl.msize},
    strobe: e.ctl.memwrite ? strobe : '0,
    data:   wdata
  };
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      v           <= 1'b0;
      e           <= '0;
      dataM_valid <= 1'b0;
      dataM       <= '0;
    end else begin
      state <= state_n;
      if (!stall_m) begin
        v <= dataE_valid;
        e <= dataE;
      end
      dataM_valid <= v & !stall_m;
      dataM <= '{
        pc:          e.pc,
        instruction: e.instruction,
        result:      (e.ctl.memread & done) ? ldata : e.result,
        dst:         e.dst,
        regwrite:    e.ctl.regwrite & !misalign,
        op:          e.ctl.op,
        misalign:    misalign
      };
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector bench for memory_access
module tb_memory_access;
  import memory_access_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic dataE_valid;
  execute_data_t dataE;
  dbus_req_t dreq;
  dbus_resp_t dresp;
  logic stall_m, dataM_valid;
  memory_data_t dataM;
  int checks = 0;
  int failures = 0;

  memory_access dut (
    .clk(clk),
    .reset(reset),
    .dataE_valid(dataE_valid),
    .dataE(dataE),
    .dreq(dreq),
    .dresp(dresp),
    .stall_m(stall_m),
    .dataM_valid(dataM_valid),
    .dataM(dataM)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [63:0] addr, memdata, rdata;
    logic rd, wr, uns, rw;
    msize_t sz;
    int ak, dk;
    logic x_req;
    int x_stall;
    logic [7:0] x_strobe;
    logic [63:0] x_wdata, x_result;
    logic x_mis, x_rw;
  } vec_t;

  function automatic vec_t mk(string n, logic [63:0] a, logic [63:0] md, logic [63:0] rdat,
                              logic r, logic w, logic u, logic rwi, msize_t s, int ak, int dk,
                              logic xr, int xs, logic [7:0] xst, logic [63:0] xwd,
                              logic [63:0] xres, logic xm, logic xrw);
    vec_t t;
    t.name = n; t.addr = a; t.memdata = md; t.rdata = rdat;
    t.rd = r; t.wr = w; t.uns = u; t.rw = rwi; t.sz = s; t.ak = ak; t.dk = dk;
    t.x_req = xr; t.x_stall = xs; t.x_strobe = xst; t.x_wdata = xwd;
    t.x_result = xres; t.x_mis = xm; t.x_rw = xrw;
    return t;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int stalls;
    logic seen, fin;
    dbus_req_t first;
    stalls = 0; seen = 1'b0; fin = 1'b0; first = '0;
    @(negedge clk);
    dataE = '0;
    dataE.pc = 64'h8000_0000 + 64'(idx * 4);
    dataE.instruction = 32'h1000 + 32'(idx);
    dataE.result = t.addr;
    dataE.memdata = t.memdata;
    dataE.dst = 5'(idx + 1);
    dataE.ctl = '{regwrite: t.rw, memread: t.rd, memwrite: t.wr, mem_unsigned: t.uns,
                  msize: t.sz, op: 5'(idx)};
    dataE_valid = 1'b1;
    dresp = '0;
    @(posedge clk);
    for (int k = 0; k < 16 && !fin; k++) begin
      @(negedge clk);
      dataE_valid = 1'b0;
      dresp.addr_ok = (k == t.ak);
      dresp.data_ok = (k == t.dk);
      dresp.data = t.rdata;
      #1;
      if (dreq.valid) begin
        if (!seen) begin
          first = dreq;
          chk({t.name, ".addr"}, dreq.addr, t.addr);
          chk({t.name, ".size"}, 64'(dreq.size), 64'(t.sz));
          chk({t.name, ".strobe"}, 64'(dreq.strobe), 64'(t.x_strobe));
          if (t.wr) chk({t.name, ".wdata"}, dreq.data, t.x_wdata);
          seen = 1'b1;
        end else begin
          checks++;
          if (dreq !== first) begin
            failures++;
            $display("FAIL %s.hold actual=%h required=%h", t.name, dreq, first);
          end
        end
      end
      if (stall_m) stalls++;
      else fin = 1'b1;
    end
    chk({t.name, ".finished"}, 64'(fin), 64'd1);
    chk({t.name, ".stalls"}, 64'(stalls), 64'(t.x_stall));
    chk({t.name, ".req"}, 64'(seen), 64'(t.x_req));
    @(posedge clk);
    #1;
    dresp = '0;
    chk({t.name, ".dataM_valid"}, 64'(dataM_valid), 64'd1);
    chk({t.name, ".valid_after"}, 64'(dreq.valid), 64'd0);
    chk({t.name, ".result"}, dataM.result, t.x_result);
    chk({t.name, ".misalign"}, 64'(dataM.misalign), 64'(t.x_mis));
    chk({t.name, ".regwrite"}, 64'(dataM.regwrite), 64'(t.x_rw));
    chk({t.name, ".pc"}, dataM.pc, 64'h8000_0000 + 64'(idx * 4));
    chk({t.name, ".dst"}, 64'(dataM.dst), 64'(idx + 1));
    @(posedge clk);
    #1;
    chk({t.name, ".valid_pulse"}, 64'(dataM_valid), 64'd0);
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = mk("add",  64'h1234, 64'h0, 64'h0, 0, 0, 0, 1, MSIZE8, -1, -1,
                0, 0, 8'h00, 64'h0, 64'h1234, 0, 1);
    vt[1]  = mk("sb",   64'h1003, 64'hAB, 64'h0, 0, 1, 0, 0, MSIZE1, 1, 3,
                1, 3, 8'h08, 64'hAB00_0000, 64'h1003, 0, 0);
    vt[2]  = mk("lh",   64'h2002, 64'h0, 64'h0000_0000_8001_0000, 1, 0, 0, 1, MSIZE2, 0, 1,
                1, 1, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 0, 1);
    vt[3]  = mk("lhu",  64'h2002, 64'h0, 64'h0000_0000_8001_0000, 1, 0, 1, 1, MSIZE2, 0, 1,
                1, 1, 8'h00, 64'h0, 64'h8001, 0, 1);
    vt[4]  = mk("ld_mis", 64'h3004, 64'h0, 64'h0, 1, 0, 0, 1, MSIZE8, 0, 0,
                0, 0, 8'h00, 64'h0, 64'h3004, 1, 0);
    vt[5]  = mk("lw_same", 64'h4004, 64'h0, 64'h7654_3210_0000_0000, 1, 0, 0, 1, MSIZE4, 1, 1,
                1, 1, 8'h00, 64'h0, 64'h7654_3210, 0, 1);
    vt[6]  = mk("sd",   64'h5000, 64'h1122_3344_5566_7788, 64'h0, 0, 1, 0, 0, MSIZE8, 2, 2,
                1, 2, 8'hFF, 64'h1122_3344_5566_7788, 64'h5000, 0, 0);
    vt[7]  = mk("sh",   64'h6006, 64'hBEEF, 64'h0, 0, 1, 0, 0, MSIZE2, 0, 2,
                1, 2, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h6006, 0, 0);
    vt[8]  = mk("lbu",  64'h7001, 64'h0, 64'h8000, 1, 0, 1, 1, MSIZE1, 0, 0,
                1, 0, 8'h00, 64'h0, 64'h80, 0, 1);
    vt[9]  = mk("lb",   64'h7001, 64'h0, 64'h8000, 1, 0, 0, 1, MSIZE1, 0, 3,
                1, 3, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1);
    vt[10] = mk("sw_mis", 64'h8002, 64'h1, 64'h0, 0, 1, 0, 0, MSIZE4, 0, 0,
                0, 0, 8'h00, 64'h0, 64'h8002, 1, 0);
    vt[11] = mk("lw",   64'h9008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 0, 1, MSIZE4, 3, 5,
                1, 5, 8'h00, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 0, 1);

    reset = 1'b1; dataE_valid = 1'b0; dataE = '0; dresp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.dreq_valid", 64'(dreq.valid), 64'd0);
    chk("rst.stall_m", 64'(stall_m), 64'd0);
    chk("rst.dataM_valid", 64'(dataM_valid), 64'd0);
    chk("rst.dataM_result", dataM.result, 64'd0);
    chk("rst.dataM_pc", dataM.pc, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // a load presented without dataE_valid must be ignored
    @(negedge clk);
    dataE = '0;
    dataE.result = 64'hA000;
    dataE.ctl.memread = 1'b1;
    dataE.ctl.regwrite = 1'b1;
    dataE.ctl.msize = MSIZE4;
    dataE_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("inv.dreq_valid", 64'(dreq.valid), 64'd0);
    chk("inv.stall_m", 64'(stall_m), 64'd0);
    @(posedge clk);
    #1;
    chk("inv.dataM_valid", 64'(dataM_valid), 64'd0);

    // reset while waiting for data_ok, then a late data_ok
    @(negedge clk);
    dataE.result = 64'h0100;
    dataE_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dataE_valid = 1'b0;
    dresp.addr_ok = 1'b1;
    #1;
    chk("mid.dreq_valid", 64'(dreq.valid), 64'd1);
    @(negedge clk);
    dresp.addr_ok = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid.data_wait_valid", 64'(dreq.valid), 64'd0);
    chk("mid.data_wait_stall", 64'(stall_m), 64'd1);
    @(posedge clk);
    #1;
    chk("mid.rst_valid", 64'(dreq.valid), 64'd0);
    chk("mid.rst_stall", 64'(stall_m), 64'd0);
    chk("mid.rst_dataM_valid", 64'(dataM_valid), 64'd0);
    chk("mid.rst_dataM", 64'(dataM.result | dataM.pc), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data = 64'h1234_5678;
    #1;
    chk("late.stall", 64'(stall_m), 64'd0);
    chk("late.dreq_valid", 64'(dreq.valid), 64'd0);
    @(posedge clk);
    #1;
    chk("late.dataM_valid", 64'(dataM_valid), 64'd0);
    @(negedge clk);
    dresp = '0;
    @(posedge clk);
    #1;
    chk("late.dataM_valid2", 64'(dataM_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
